// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue controller: opcodes, FSM states, sizes.
package alu_pkg;

    localparam int REG_COUNT = 8;
    localparam int REG_AW    = 3;
    localparam int DATA_W    = 16;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_LLS = 4'b0111;
    localparam logic [3:0] OP_LRS = 4'b1000;
    localparam logic [3:0] OP_INC = 4'b1001;
    localparam logic [3:0] OP_DEC = 4'b1010;
    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        CAPT    = 2'd2,
        CAPT_HI = 2'd3
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_DEC;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8 x 16 register file: one synchronous write port, two operand reads and one debug read.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [REG_COUNT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to an external registered ALU and writes results back.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid,
    input  logic [15:0]              instr,
    output logic                     instr_ready,
    input  logic                     wr_en,
    input  logic [REG_AW-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [REG_AW-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic [3:0]               alu_opcode,
    output logic signed [DATA_W-1:0] alu_operand_a,
    output logic signed [DATA_W-1:0] alu_operand_b,
    input  logic signed [31:0]       alu_result,
    output logic                     done,
    output logic                     err
);

    state_t            state;
    logic [3:0]        op_q;
    logic [REG_AW-1:0] rd_q;

    logic [3:0]        in_op;
    logic [REG_AW-1:0] in_rd;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic              unused_instr_bits;

    assign in_op             = instr[15:12];
    assign in_rd             = instr[11:9];
    assign in_rs1            = instr[8:6];
    assign in_rs2            = instr[5:3];
    assign unused_instr_bits = ^instr[2:0];

    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;

    // Internal result writes own the port in CAPT/CAPT_HI; external writes only land in IDLE.
    logic              int_we;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    always_comb begin
        int_we   = (state == CAPT) || (state == CAPT_HI);
        rf_we    = int_we || (wr_en && (state == IDLE));
        rf_waddr = wr_addr;
        rf_wdata = wr_data;
        if (state == CAPT) begin
            rf_waddr = rd_q;
            rf_wdata = alu_result[15:0];
        end else if (state == CAPT_HI) begin
            rf_waddr = REG_AW'(rd_q + 1'b1);
            rf_wdata = alu_result[31:16];
        end
    end

    alu_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr_a  (in_rs1),
        .rdata_a  (rdata_a),
        .raddr_b  (in_rs2),
        .rdata_b  (rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign instr_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_q          <= OP_NOP;
            rd_q          <= '0;
            alu_opcode    <= OP_NOP;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        op_q          <= in_op;
                        rd_q          <= in_rd;
                        alu_opcode    <= in_op;
                        alu_operand_a <= rdata_a;
                        alu_operand_b <= ((in_op == OP_INC) || (in_op == OP_DEC)) ? '0 : rdata_b;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal ops and divide-by-zero abort before any write-back.
                    if (!op_legal(op_q) || ((op_q == OP_DIV) && (alu_operand_b == '0))) begin
                        alu_opcode <= OP_NOP;
                        done       <= 1'b1;
                        err        <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    alu_opcode <= OP_NOP;
                    if (op_q == OP_MUL) begin
                        state <= CAPT_HI;
                    end else begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                CAPT_HI: begin
                    alu_opcode <= OP_NOP;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: emulates the registered ALU and checks against a register-array model.
module tb_alu_issue_ctrl;

    logic               clk = 1'b0;
    logic               reset;
    logic               instr_valid;
    logic [15:0]        instr;
    logic               instr_ready;
    logic               wr_en;
    logic [2:0]         wr_addr;
    logic [15:0]        wr_data;
    logic [2:0]         dbg_addr;
    logic [15:0]        dbg_data;
    logic [3:0]         alu_opcode;
    logic signed [15:0] alu_operand_a;
    logic signed [15:0] alu_operand_b;
    logic signed [31:0] alu_result = '0;
    logic               done;
    logic               err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] ref_rf [8];

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data),
        .alu_opcode    (alu_opcode),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_result    (alu_result),
        .done          (done),
        .err           (err)
    );

    // Arithmetic meaning of each opcode, on plain integers.
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic signed [15:0] a,
                                           input logic signed [15:0] b);
        int ai;
        int bi;
        logic [15:0] au;
        ai = a;
        bi = b;
        au = a;
        case (op)
            4'd0:    return ai + bi;
            4'd1:    return ai - bi;
            4'd2:    return ai * bi;
            4'd3:    return (bi == 0) ? 32'd0 : ai / bi;
            4'd4:    return ai & bi;
            4'd5:    return ai | bi;
            4'd6:    return ai ^ bi;
            4'd7:    return ai << b[3:0];
            4'd8:    return {16'h0, au >> b[3:0]};
            4'd9:    return ai + 1;
            4'd10:   return ai - 1;
            default: return 32'd0;
        endcase
    endfunction

    always_ff @(posedge clk) alu_result <= alu_fn(alu_opcode, alu_operand_a, alu_operand_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_reg(input string tag, input int idx, input logic [15:0] exp);
        dbg_addr = 3'(idx);
        #1;
        check($sformatf("%s_R%0d", tag, idx), {16'h0, dbg_data}, {16'h0, exp});
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) check_reg(tag, i, ref_rf[i]);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        ref_rf[a] = d;
    endtask

    // Issue one instruction, optionally with a same-cycle external write, and keep
    // hammering external writes while the block is busy (they must be ignored).
    task automatic run_instr(input string tag, input logic [3:0] op, input logic [2:0] rd,
                             input logic [2:0] rs1, input logic [2:0] rs2,
                             input bit do_wr, input logic [2:0] wa, input logic [15:0] wd);
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic [31:0] res;
        bit abort;
        int exp_lat;
        int lat;
        a = ref_rf[rs1];
        b = (op == 4'd9 || op == 4'd10) ? 16'sd0 : ref_rf[rs2];
        abort = (op > 4'd10) || (op == 4'd3 && b == 16'sd0);
        exp_lat = abort ? 1 : ((op == 4'd2) ? 3 : 2);
        res = alu_fn(op, a, b);
        @(negedge clk);
        check({tag, "_ready_before"}, {31'h0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr = {op, rd, rs1, rs2, 3'($urandom)};
        wr_en = do_wr; wr_addr = wa; wr_data = wd;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 3'($urandom); wr_data = 16'($urandom);
        check({tag, "_opcode_exec"}, {28'h0, alu_opcode}, {28'h0, op});
        check({tag, "_operand_a"}, {16'h0, alu_operand_a}, {16'h0, a});
        check({tag, "_operand_b"}, {16'h0, alu_operand_b}, {16'h0, b});
        if (do_wr) ref_rf[wa] = wd;
        if (!abort) begin
            ref_rf[rd] = res[15:0];
            if (op == 4'd2) ref_rf[(rd + 1) % 8] = res[31:16];
        end
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_err"}, {31'h0, err}, {31'h0, abort});
        check({tag, "_ready_at_done"}, {31'h0, instr_ready}, 32'd1);
        check({tag, "_opcode_idle"}, {28'h0, alu_opcode}, 32'hF);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'h0, done}, 32'd0);
        check_regs(tag);
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0; instr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, instr_ready}, 32'd1);
        check("rst_done", {30'h0, done, err}, 32'd0);
        check("rst_opcode", {28'h0, alu_opcode}, 32'hF);
        check("rst_operands", {alu_operand_a, alu_operand_b}, 32'd0);
        check_regs("rst");
        @(negedge clk) reset = 1'b0;

        // ADD of two negatives
        wr_reg(3'd1, 16'hFFF6);
        wr_reg(3'd2, 16'hFFF5);
        run_instr("add", 4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
        check_reg("add_const", 3, 16'hFFEB);

        // MUL with high half wrapping into R0
        wr_reg(3'd1, 16'd300);
        wr_reg(3'd2, 16'd300);
        run_instr("mul", 4'd2, 3'd7, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
        check_reg("mul_const", 7, 16'h5F90);
        check_reg("mul_const", 0, 16'h0001);

        // DIV by zero aborts
        wr_reg(3'd1, 16'd25);
        wr_reg(3'd2, 16'd0);
        run_instr("div0", 4'd3, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);

        // Illegal op, then LLS
        run_instr("illegal", 4'd12, 3'd5, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
        wr_reg(3'd1, 16'd10);
        wr_reg(3'd2, 16'd2);
        run_instr("lls", 4'd7, 3'd6, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
        check_reg("lls_const", 6, 16'd40);

        // Same-cycle external write and INC acceptance
        wr_reg(3'd1, 16'd45);
        run_instr("inc_wr", 4'd9, 3'd2, 3'd1, 3'd5, 1'b1, 3'd1, 16'd5);
        check_reg("inc_const", 2, 16'd46);
        check_reg("inc_const", 1, 16'd5);

        // Reset during CAPT_HI of a multiply
        wr_reg(3'd1, 16'd300);
        wr_reg(3'd2, 16'd300);
        @(negedge clk);
        instr_valid = 1'b1;
        instr = {4'd2, 3'd7, 3'd1, 3'd2, 3'd0};
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
        check("rstmid_ready", {31'h0, instr_ready}, 32'd1);
        check("rstmid_done", {30'h0, done, err}, 32'd0);
        check("rstmid_opcode", {28'h0, alu_opcode}, 32'hF);
        check_regs("rstmid");
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("rstrel_ready", {31'h0, instr_ready}, 32'd1);
        check("rstrel_done", {31'h0, done}, 32'd0);
        @(posedge clk); #1;
        check("rstrel_done2", {31'h0, done}, 32'd0);
        check_regs("rstrel");
        wr_reg(3'd1, 16'd1234);
        wr_reg(3'd2, 16'd4321);
        run_instr("add_post", 4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
        check_reg("addpost_const", 3, 16'd5555);

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            logic [3:0] op;
            logic [2:0] rd, rs1, rs2;
            op  = 4'($urandom);
            rd  = 3'($urandom);
            rs1 = 3'($urandom);
            rs2 = 3'($urandom);
            if ($urandom_range(0, 3) == 0) wr_reg(3'($urandom), 16'($urandom));
            if (op == 4'd3 && $urandom_range(0, 1) == 1) wr_reg(rs2, 16'h0);
            run_instr($sformatf("rnd%0d", n), op, rd, rs1, rs2,
                      1'($urandom), 3'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
